// File: rtl/dsp_simd_pack_pkg.sv
// Shared definitions for the four-lane SIMD operand packer.
// Optional partial-vector close is enabled by DSP_SIMD_PACK_LAST_EN.
package dsp_simd_pkg;

    localparam int LANES      = 4;
    localparam int LANE_WIDTH = 12;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        HOLD = 1'b1
    } state_e;

    typedef logic [LANES-1:0] mask_t;

endpackage

// File: rtl/dsp_simd_pack_if.sv
// Scalar-pair input stream and four-lane vector output of the packer.
// in_last exists only when DSP_SIMD_PACK_LAST_EN is defined.
interface dsp_simd_pack_if #(
    parameter int WIDTH = 12
);
    logic                in_valid;
    logic                in_ready;
    logic [WIDTH-1:0]    in_a;
    logic [WIDTH-1:0]    in_b;
`ifdef DSP_SIMD_PACK_LAST_EN
    logic                in_last;
`endif
    logic                out_valid;
    logic                out_ready;
    logic [WIDTH-1:0]    a0, a1, a2, a3;
    logic [WIDTH-1:0]    b0, b1, b2, b3;
    dsp_simd_pkg::mask_t out_mask;

    modport master (
        output in_valid, in_a, in_b,
`ifdef DSP_SIMD_PACK_LAST_EN
        output in_last,
`endif
        output out_ready,
        input  in_ready, out_valid, a0, a1, a2, a3, b0, b1, b2, b3, out_mask
    );

    modport slave (
        input  in_valid, in_a, in_b,
`ifdef DSP_SIMD_PACK_LAST_EN
        input  in_last,
`endif
        input  out_ready,
        output in_ready, out_valid, a0, a1, a2, a3, b0, b1, b2, b3, out_mask
    );

endinterface

// File: rtl/dsp_simd_pack.sv
// Gathers four scalar (a, b) pairs into one SIMD vector with a lane mask.
// DSP_SIMD_PACK_LAST_EN adds in_last to close partial vectors early.
module dsp_simd_pack
    import dsp_simd_pkg::*;
#(
    parameter int WIDTH = 12
) (
    input  logic           clk_i,
    input  logic           rst_n_i,
    dsp_simd_pack_if.slave bus
);

    if (WIDTH < 1 || WIDTH > LANE_WIDTH) begin : g_width_chk
        $error("dsp_simd_pack: WIDTH=%0d outside legal range 1..%0d", WIDTH, LANE_WIDTH);
    end

    state_e           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    mask_t            mask_q, mask_d;
    logic [WIDTH-1:0] lane_a_q [LANES];
    logic [WIDTH-1:0] lane_a_d [LANES];
    logic [WIDTH-1:0] lane_b_q [LANES];
    logic [WIDTH-1:0] lane_b_d [LANES];

    logic last;
    logic in_ready;
    logic in_fire;
    logic out_fire;

`ifdef DSP_SIMD_PACK_LAST_EN
    assign last = bus.in_last;
`else
    assign last = 1'b0;
`endif

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign in_ready = rst_n_i & ((state_q == FILL) | bus.out_ready);
    assign in_fire  = bus.in_valid & in_ready;
    assign out_fire = (state_q == HOLD) & bus.out_ready;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mask_d   = mask_q;
        lane_a_d = lane_a_q;
        lane_b_d = lane_b_q;
        case (state_q)
            FILL: begin
                if (in_fire) begin
                    lane_a_d[cnt_q] = bus.in_a;
                    lane_b_d[cnt_q] = bus.in_b;
                    mask_d[cnt_q]   = 1'b1;
                    if (cnt_q == 2'd3 || last) begin
                        state_d = HOLD;
                        cnt_d   = 2'd0;
                    end else begin
                        cnt_d = cnt_q + 2'd1;
                    end
                end
            end
            HOLD: begin
                if (out_fire) begin
                    for (int i = 0; i < LANES; i++) begin
                        lane_a_d[i] = '0;
                        lane_b_d[i] = '0;
                    end
                    mask_d  = '0;
                    state_d = FILL;
                    cnt_d   = 2'd0;
                    // A pair accepted alongside the outgoing vector starts the next one.
                    if (in_fire) begin
                        lane_a_d[0] = bus.in_a;
                        lane_b_d[0] = bus.in_b;
                        mask_d      = 4'b0001;
                        if (last) begin
                            state_d = HOLD;
                        end else begin
                            cnt_d = 2'd1;
                        end
                    end
                end
            end
            default: begin
                state_d = FILL;
                cnt_d   = 2'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= FILL;
            cnt_q   <= 2'd0;
            mask_q  <= '0;
            for (int i = 0; i < LANES; i++) begin
                lane_a_q[i] <= '0;
                lane_b_q[i] <= '0;
            end
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            lane_a_q <= lane_a_d;
            lane_b_q <= lane_b_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_mask  = mask_q;
    assign bus.a0        = lane_a_q[0];
    assign bus.a1        = lane_a_q[1];
    assign bus.a2        = lane_a_q[2];
    assign bus.a3        = lane_a_q[3];
    assign bus.b0        = lane_b_q[0];
    assign bus.b1        = lane_b_q[1];
    assign bus.b2        = lane_b_q[2];
    assign bus.b3        = lane_b_q[3];

endmodule

// File: tb/tb_dsp_simd_pack.sv
// Directed bench for dsp_simd_pack: full vectors, backpressure, reset, partial close, width 5.
module tb_dsp_simd_pack;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    dsp_simd_pack_if #(.WIDTH(12)) bus ();
    dsp_simd_pack_if #(.WIDTH(5))  bus5 ();

    dsp_simd_pack #(.WIDTH(12)) u_dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    dsp_simd_pack #(.WIDTH(5)) u_dut5 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus5)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv(input logic v, input logic [11:0] a, input logic [11:0] b,
                       input logic last, input logic ordy);
        bus.in_valid  = v;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.out_ready = ordy;
`ifdef DSP_SIMD_PACK_LAST_EN
        bus.in_last   = last;
`else
        if (last) $display("note: in_last ignored in this build");
`endif
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [3:0] m,
                           input logic [11:0] e0, input logic [11:0] e1,
                           input logic [11:0] e2, input logic [11:0] e3);
        check({tag, "_valid"}, 32'(bus.out_valid), 32'(v));
        check({tag, "_mask"},  32'(bus.out_mask),  32'(m));
        check({tag, "_a0"},    32'(bus.a0),        32'(e0));
        check({tag, "_a1"},    32'(bus.a1),        32'(e1));
        check({tag, "_a2"},    32'(bus.a2),        32'(e2));
        check({tag, "_a3"},    32'(bus.a3),        32'(e3));
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        drv(1'b0, 12'h0, 12'h0, 1'b0, 1'b0);
        bus5.in_valid  = 1'b0;
        bus5.in_a      = '0;
        bus5.in_b      = '0;
        bus5.out_ready = 1'b0;
`ifdef DSP_SIMD_PACK_LAST_EN
        bus5.in_last   = 1'b0;
`endif
        repeat (2) @(posedge clk);
        #1;
        chk_out("reset", 1'b0, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0);
        check("reset_rdy", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b1;
        #1 check("rel_rdy", 32'(bus.in_ready), 32'd1);

        // Eight back-to-back pairs, out_ready high: two full vectors, no bubble.
        for (int i = 1; i <= 8; i++) begin
            drv(1'b1, 12'(i), 12'(32'h10 + i - 1), 1'b0, 1'b1);
            #1 check("t1_rdy", 32'(bus.in_ready), 32'd1);
            tick();
            if (i == 4) begin
                chk_out("t1_v1", 1'b1, 4'hF, 12'd1, 12'd2, 12'd3, 12'd4);
                check("t1_v1_b0", 32'(bus.b0), 32'h10);
                check("t1_v1_b3", 32'(bus.b3), 32'h13);
            end
            if (i == 5) begin
                check("t1_p5_valid", 32'(bus.out_valid), 32'd0);
                check("t1_p5_mask",  32'(bus.out_mask),  32'h1);
            end
            if (i == 8) begin
                chk_out("t1_v2", 1'b1, 4'hF, 12'd5, 12'd6, 12'd7, 12'd8);
                check("t1_v2_b3", 32'(bus.b3), 32'h17);
            end
        end
        drv(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        tick();
        chk_out("drain", 1'b0, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0);

        // Backpressure: three stalled cycles, then the fifth pair lands in lane 0.
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 12'(32'h21 + i), 12'(32'h31 + i), 1'b0, 1'b0);
            tick();
        end
        chk_out("bp_full", 1'b1, 4'hF, 12'h21, 12'h22, 12'h23, 12'h24);
        drv(1'b1, 12'h25, 12'h35, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1 check("bp_rdy", 32'(bus.in_ready), 32'd0);
            tick();
            chk_out("bp_hold", 1'b1, 4'hF, 12'h21, 12'h22, 12'h23, 12'h24);
        end
        drv(1'b1, 12'h25, 12'h35, 1'b0, 1'b1);
        #1 check("bp_rel_rdy", 32'(bus.in_ready), 32'd1);
        tick();
        chk_out("bp_rel", 1'b0, 4'h1, 12'h25, 12'h0, 12'h0, 12'h0);
        check("bp_rel_b0", 32'(bus.b0), 32'h35);

        // Reset mid-fill with three pairs held.
        drv(1'b1, 12'h26, 12'h36, 1'b0, 1'b1);
        tick();
        drv(1'b1, 12'h27, 12'h37, 1'b0, 1'b1);
        tick();
        check("pre_rst_mask", 32'(bus.out_mask), 32'h7);
        drv(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk_out("mid_rst", 1'b0, 4'h0, 12'h0, 12'h0, 12'h0, 12'h0);
        check("mid_rst_rdy", 32'(bus.in_ready), 32'd0);
        #2 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drv(1'b1, 12'(32'h41 + i), 12'(32'h51 + i), 1'b0, 1'b1);
            tick();
        end
        chk_out("post_rst", 1'b1, 4'hF, 12'h41, 12'h42, 12'h43, 12'h44);
        drv(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        tick();

`ifdef DSP_SIMD_PACK_LAST_EN
        // Partial close after two pairs, then single-pair vectors every cycle.
        drv(1'b1, 12'd9, 12'h19, 1'b0, 1'b1);
        tick();
        drv(1'b1, 12'd10, 12'h1A, 1'b1, 1'b1);
        tick();
        chk_out("part", 1'b1, 4'h3, 12'd9, 12'd10, 12'h0, 12'h0);
        check("part_b2", 32'(bus.b2), 32'h0);
        check("part_b3", 32'(bus.b3), 32'h0);
        for (int k = 0; k < 3; k++) begin
            drv(1'b1, 12'(32'h61 + k), 12'(32'h71 + k), 1'b1, 1'b1);
            #1 check("single_rdy", 32'(bus.in_ready), 32'd1);
            tick();
            chk_out("single", 1'b1, 4'h1, 12'(32'h61 + k), 12'h0, 12'h0, 12'h0);
        end
        drv(1'b0, 12'h0, 12'h0, 1'b0, 1'b1);
        tick();
`endif

        // Narrow lanes: values are stored as-is, no extension.
        for (int i = 0; i < 4; i++) begin
            bus5.in_valid  = 1'b1;
            bus5.in_a      = (i == 0) ? 5'h1F : 5'(i);
            bus5.in_b      = 5'(32'h10 + i);
            bus5.out_ready = 1'b1;
            tick();
        end
        bus5.in_valid = 1'b0;
        check("w5_valid", 32'(bus5.out_valid), 32'd1);
        check("w5_mask",  32'(bus5.out_mask),  32'hF);
        check("w5_a0",    32'(bus5.a0),        32'h1F);
        check("w5_a3",    32'(bus5.a3),        32'h3);
        check("w5_b1",    32'(bus5.b1),        32'h11);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
